// File: rtl/multiport_regfile_pkg.sv
// Shared constants and clear-sequencer state encoding for the multiport register file.
// Imported by the top and by the clear sequencer.
package multiport_regfile_pkg;

  localparam logic HIGH     = 1'b1;
  localparam logic LOW      = 1'b0;
  // Active-low enable levels, used for we_
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage : multiport_regfile_pkg

// File: rtl/regfile_clr_seq.sv
// Clear sweep sequencer: on an accepted request, walks the clear index 0..DEPTH-1,
// one entry per cycle, and strobes the array to zero that entry.
module regfile_clr_seq
  import multiport_regfile_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              busy,
  output logic [ADDR_W-1:0] clr_idx,
  output logic              clr_stb
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;
  localparam logic [ADDR_W-1:0] ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req == HIGH) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        // Requests during a sweep are ignored; the counter wraps back to 0 on exit
        cnt_d = cnt_q + ONE;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy    = (state_q == ST_CLEAR);
  assign clr_stb = (state_q == ST_CLEAR);
  assign clr_idx = cnt_q;

endmodule : regfile_clr_seq

// File: rtl/multiport_regfile.sv
// One-write, two-read register file with registered reads, write-through bypass
// and a whole-array clear sweep that discards writes while it runs.
module multiport_regfile
  import multiport_regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [DATA_W-1:0] rd0_data,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              seq_busy;
  logic              clr_stb;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_req;
  logic              wr_ok;
  logic              wr_drop_q, wr_drop_d;

  logic [1:0][ADDR_W-1:0] rd_addr;

  regfile_clr_seq #(
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk     (clk),
    .reset   (reset),
    .clr_req (clr_req),
    .busy    (seq_busy),
    .clr_idx (clr_idx),
    .clr_stb (clr_stb)
  );

  // A write only lands when idle and no clear is being accepted on the same edge
  assign wr_req = (we_ == ENABLE_);
  assign wr_ok  = wr_req && !seq_busy && (clr_req == LOW);

  always_comb begin
    mem_d = mem_q;
    if (clr_stb) begin
      mem_d[clr_idx] = '0;
    end else if (wr_ok) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  assign wr_drop_d = wr_req && !wr_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_drop_q <= LOW;
    end else begin
      mem_q     <= mem_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  assign rd_addr = {rd1_addr, rd0_addr};

  // Reading the next-state array gives both write-through and clear bypass for free
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    always_comb begin
      rd_data_d = mem_d[rd_addr[gi]];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_data_q <= '0;
      end else begin
        rd_data_q <= rd_data_d;
      end
    end
  end

  assign rd0_data = g_rd[0].rd_data_q;
  assign rd1_data = g_rd[1].rd_data_q;
  assign busy     = seq_busy;
  assign wr_drop  = wr_drop_q;

endmodule : multiport_regfile

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning address width; depth DEPTH = 2**ADDR_W entries.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, named as below.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 we_  input  1  write enable, active-low.
REQ-007 wr_addr  input  ADDR_W  write address.
REQ-008 wr_data  input  DATA_W  write data.
REQ-009 rd0_addr  input  ADDR_W  read port 0 address.
REQ-010 rd0_data  output  DATA_W  read port 0 data, registered.
REQ-011 rd1_addr  input  ADDR_W  read port 1 address.
REQ-012 rd1_data  output  DATA_W  read port 1 data, registered.
REQ-013 clr_req  input  1  active-high request to zero the whole array.
REQ-014 busy  output  1  high while a clear sweep runs.
REQ-015 wr_drop  output  1  one-cycle pulse: a write was discarded.

Function
REQ-016 The write SHALL commit wr_data to entry wr_addr at the rising edge where we_ is low and the state is IDLE.
REQ-017 Each read port SHALL present entry contents for the address sampled at edge N on its data output after edge N (one-cycle latency), both ports independent and simultaneous.
REQ-018 When a read address equals wr_addr at an edge where a write commits, that port SHALL output the new wr_data (write-through bypass), not the old contents.
REQ-019 Both read ports addressing the same entry SHALL return identical data.
REQ-020 The FSM SHALL have states IDLE and CLEAR; IDLE -> CLEAR when clr_req is high at an edge in IDLE; CLEAR -> IDLE after the entry DEPTH-1 is zeroed.
REQ-021 In CLEAR, a counter SHALL zero one entry per cycle, ascending from 0 to DEPTH-1, so a sweep takes exactly DEPTH cycles; busy SHALL be high for exactly those DEPTH cycles, starting the cycle after clr_req is sampled.
REQ-022 clr_req while in CLEAR SHALL be ignored (no restart, no extension).
REQ-023 A write requested (we_ low) in CLEAR, or in the same edge that clr_req is accepted, SHALL be discarded and wr_drop SHALL pulse high for the following cycle.
REQ-024 Reads in CLEAR SHALL continue with one-cycle latency; an entry already swept returns zero; the entry being zeroed at that edge returns zero (clear bypass).
REQ-025 The counter SHALL wrap to 0 on completing DEPTH-1; no out-of-range address exists since DEPTH = 2**ADDR_W.
REQ-026 Writes in the cycle after CLEAR -> IDLE SHALL be accepted normally.

Reset
REQ-027 Asserting reset at any time SHALL immediately zero all entries, set rd0_data = rd1_data = 0, busy = 0, wr_drop = 0, counter = 0, state = IDLE.
REQ-028 Reset asserted mid-sweep SHALL abort the sweep; no clear resumes after release.
REQ-029 The first edge after reset deassertion SHALL accept writes, reads and clr_req normally.

Structure
REQ-030 HIGH/LOW, ENABLE_/DISABLE_ constants and FSM state encodings SHALL live in the shared header multiport_regfile.h.
REQ-031 The clear FSM and counter SHALL be a sub-module named regfile_clr_seq (outputs: busy, clear index, clear strobe); the array, bypass and read registers stay in the top.

Verification
REQ-032 After reset release, write entry i with value i for all i, read each on rd0 next cycle -> rd0_data == i, all DEPTH checks OK.
REQ-033 Write 0xA5A5A5A5 to addr 3 while rd0_addr = rd1_addr = 3 same edge -> both rd0_data and rd1_data == 0xA5A5A5A5 next cycle.
REQ-034 Fill array, pulse clr_req one cycle -> busy high exactly 32 cycles, then all entries read 0; second clr_req at sweep cycle 10 -> busy still 32 cycles total.
REQ-035 Fill array, clr_req, then we_ low to addr 31 with 0x1 in sweep cycle 5 -> wr_drop pulses once, addr 31 reads 0 after sweep.
REQ-036 Fill array, clr_req, assert reset at sweep cycle 16 -> busy drops immediately, all entries read 0, write to addr 7 with 0x7 on first edge after release reads back 0x7.
